// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback over a shared datapath, with a ready/wait memory handshake and a
// stall timeout that parks the FSM in ERROR.
// Handshake: a memory access is requested (mem_read/mem_write) for as long as
// the FSM sits in FETCH, MEM_RD or MEM_WR; it completes in the cycle where
// mem_ready is high, and mem_ready is ignored in every other state.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes go to TRAP and raise the
// extra trap output; without it they retire as a two-cycle NOP.
module multicycle_controller #(
   parameter int WAIT_MAX = 15,
   parameter int ALUOP_W  = 2
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [6:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               pc_source,
   output logic               instr_done,
   output logic               bus_err,
`ifdef ILLEGAL_TRAP_EN
   output logic               trap,
`endif
   output logic [3:0]         state_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      EXEC_I   = 4'd7,
      ALU_WB   = 4'd8,
      BRANCH   = 4'd9,
      ERROR    = 4'd10,
      TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;

   localparam logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] OP_SUB   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] OP_FUNCT = ALUOP_W'(2);

   // Counter must hold WAIT_MAX-1; keep at least one bit when WAIT_MAX is 0 or 1.
   localparam int CW = ($clog2(WAIT_MAX + 1) < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] LIMIT = CW'((WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0);

   state_t        state, next_state;
   logic [CW-1:0] wait_cnt;
   logic          in_mem, stall, tmo_hit, timeout;

   assign in_mem  = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
   assign stall   = in_mem && !mem_ready;
   assign tmo_hit = (WAIT_MAX > 0) && stall && (wait_cnt == LIMIT);
   assign state_o = state;

`ifdef ILLEGAL_TRAP_EN
   assign trap = (state == TRAP) && !RESET;
`endif

   // State, wait counter, sticky bus error and retire pulse.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= FETCH;
         wait_cnt   <= '0;
         bus_err    <= 1'b0;
         instr_done <= 1'b0;
      end else begin
         state      <= next_state;
         if (next_state != state) wait_cnt <= '0;
         else if (stall)          wait_cnt <= wait_cnt + CW'(1);
         bus_err    <= bus_err | timeout;
         instr_done <= (next_state == FETCH) && (state != FETCH);
      end
   end

   // Next-state and control decode; everything is held at 0 during reset.
   always_comb begin
      next_state = state;
      timeout    = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = OP_ADD;
      pc_source  = 1'b0;
      case (state)
         FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               alu_src_b  = 2'b01;
               next_state = DECODE;
            end else if (tmo_hit) begin
               timeout    = 1'b1;
               next_state = ERROR;
            end
         end
         DECODE: begin
            // PC-relative target lands in ALUOut for a possible branch.
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            case (opcode)
               OPC_R:               next_state = EXEC_R;
               OPC_I:               next_state = EXEC_I;
               OPC_LOAD, OPC_STORE: next_state = MEM_ADDR;
               OPC_BR:              next_state = BRANCH;
`ifdef ILLEGAL_TRAP_EN
               default:             next_state = TRAP;
`else
               default:             next_state = FETCH;
`endif
            endcase
         end
         MEM_ADDR: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            next_state = (opcode == OPC_STORE) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) next_state = MEM_WB;
            else if (tmo_hit) begin
               timeout    = 1'b1;
               next_state = ERROR;
            end
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            next_state = FETCH;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) next_state = FETCH;
            else if (tmo_hit) begin
               timeout    = 1'b1;
               next_state = ERROR;
            end
         end
         EXEC_R: begin
            alu_src_a  = 2'b01;
            alu_op     = OP_FUNCT;
            next_state = ALU_WB;
         end
         EXEC_I: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            alu_op     = OP_FUNCT;
            next_state = ALU_WB;
         end
         ALU_WB: begin
            reg_write  = 1'b1;
            next_state = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 2'b01;
            alu_op     = OP_SUB;
            pc_source  = 1'b1;
            pc_write   = zero;
            next_state = FETCH;
         end
         default: next_state = state;
      endcase
      if (RESET) begin
         timeout    = 1'b0;
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b00;
         alu_op     = OP_ADD;
         pc_source  = 1'b0;
      end
   end

endmodule
